// File: rtl/cpu_pkg.sv
// Shared types for the register-file sequencer: instruction layout, ALU opcodes, FSM states.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 2;

   typedef enum logic [1:0] {
      AluAdd = 2'b00,
      AluSub = 2'b01,
      AluAnd = 2'b10,
      AluNop = 2'b11
   } alu_op_e;

   typedef struct packed {
      alu_op_e                 op;
      logic [REG_ADDR_W-1:0]   rd;
      logic [REG_ADDR_W-1:0]   rs1;
      logic [REG_ADDR_W-1:0]   rs2;
   } instr_t;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StWrite,
      StDone
   } seq_state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Control, instruction-memory and register-file signals of the sequencer.
interface regfile_sequencer_if
   import cpu_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = 4,
   parameter int unsigned ITER_WIDTH = 8
) ();

   logic                    start;
   logic                    abort;
   logic [PC_WIDTH-1:0]     prog_last;
   logic [ITER_WIDTH-1:0]   iter_cnt;
   logic [PC_WIDTH-1:0]     im_addr;
   logic [7:0]              im_data;
   logic [REG_ADDR_W-1:0]   rs1;
   logic [REG_ADDR_W-1:0]   rs2;
   logic [REG_ADDR_W-1:0]   rd;
   alu_op_e                 alu_op;
   logic                    reg_we;
   logic                    busy;
   logic                    done;
   logic [ITER_WIDTH-1:0]   iter_left;

   // master: the sequencer itself
   modport master (
      input  start, abort, prog_last, iter_cnt, im_data,
      output im_addr, rs1, rs2, rd, alu_op, reg_we, busy, done, iter_left
   );

   modport slave (
      output start, abort, prog_last, iter_cnt, im_data,
      input  im_addr, rs1, rs2, rd, alu_op, reg_we, busy, done, iter_left
   );

endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle FETCH/EXEC/WRITE controller that replays a short program a programmable
// number of times against the register file and ALU.
module regfile_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned REGF_WIDTH = 16,
   parameter int unsigned IM_DEPTH   = 16,
   parameter int unsigned PC_WIDTH   = $clog2(IM_DEPTH),
   parameter int unsigned ITER_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   regfile_sequencer_if.master bus
);

   // iter_left is reported on the data path, so it has to fit in a register word
   if (ITER_WIDTH > REGF_WIDTH) begin : g_iter_width_check
      $error("ITER_WIDTH must not exceed REGF_WIDTH");
   end

   seq_state_e              state_q, state_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic [PC_WIDTH-1:0]     prog_last_q, prog_last_d;
   instr_t                  ir_q, ir_d;
   logic [ITER_WIDTH-1:0]   iter_left_q, iter_left_d;
   logic                    reg_we;
   logic                    busy;
   logic                    done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         prog_last_q <= '0;
         ir_q        <= '0;
         iter_left_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         prog_last_q <= prog_last_d;
         ir_q        <= ir_d;
         iter_left_q <= iter_left_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      prog_last_d = prog_last_q;
      ir_d        = ir_q;
      iter_left_d = iter_left_q;
      reg_we      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            // abort outranks start when both arrive together
            if (bus.start && !bus.abort) begin
               prog_last_d = bus.prog_last;
               iter_left_d = bus.iter_cnt;
               pc_d        = '0;
               state_d     = (bus.iter_cnt == '0) ? StDone : StFetch;
            end
         end
         StFetch: begin
            busy = 1'b1;
            if (bus.abort) begin
               state_d = StIdle;
            end else begin
               ir_d    = instr_t'(bus.im_data);
               state_d = StExec;
            end
         end
         StExec: begin
            busy    = 1'b1;
            state_d = bus.abort ? StIdle : StWrite;
         end
         StWrite: begin
            busy = 1'b1;
            if (bus.abort) begin
               state_d = StIdle;
            end else begin
               reg_we = (ir_q.op != AluNop);
               if (pc_q != prog_last_q) begin
                  pc_d    = pc_q + PC_WIDTH'(1);
                  state_d = StFetch;
               end else if (iter_left_q == ITER_WIDTH'(1)) begin
                  state_d = StDone;
               end else begin
                  iter_left_d = iter_left_q - ITER_WIDTH'(1);
                  pc_d        = '0;
                  state_d     = StFetch;
               end
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Decode fields come straight from ir, so they hold their value until the next fetch
   assign bus.im_addr   = pc_q;
   assign bus.rs1       = ir_q.rs1;
   assign bus.rs2       = ir_q.rs2;
   assign bus.rd        = ir_q.rd;
   assign bus.alu_op    = ir_q.op;
   assign bus.reg_we    = reg_we;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.iter_left = iter_left_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: table of program runs checked cycle by cycle, plus abort/reset/start corner cases.
module tb_regfile_sequencer;

   logic clk = 1'b0;
   logic rst;

   regfile_sequencer_if #(.PC_WIDTH(4), .ITER_WIDTH(8)) bus ();

   regfile_sequencer #(
      .REGF_WIDTH(16),
      .IM_DEPTH  (16),
      .PC_WIDTH  (4),
      .ITER_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  im [16];
   logic [15:0] rf [4];

   always_comb bus.im_data = im[bus.im_addr];

   int checks   = 0;
   int failures = 0;
   int wr_cnt   = 0;

   typedef struct packed {
      logic [3:0]       pl;
      logic [7:0]       k;
      logic [3:0][7:0]  prog;
      logic [7:0]       exp_writes;
      logic [7:0]       exp_done;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b,
                                       input logic [1:0] op);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a;
      endcase
   endfunction

   // Register-file model commits the write presented this cycle, then advances one cycle
   task automatic tick();
      if (bus.reg_we === 1'b1) begin
         rf[bus.rd] = alu(rf[bus.rs1], rf[bus.rs2], bus.alu_op);
         wr_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rf_init();
      rf[0] = 16'd0;
      rf[1] = 16'd1;
      rf[2] = 16'd0;
      rf[3] = 16'd0;
      wr_cnt = 0;
   endtask

   task automatic load_fib();
      for (int i = 0; i < 16; i++) im[i] = 8'hC0;
      im[0] = 8'h21;  // r2 = r0 + r1
      im[1] = 8'h07;  // r0 = r1 + r3
      im[2] = 8'h1B;  // r1 = r2 + r3
   endtask

   initial begin
      int n, k, dc, idx, fa, fb, fc;
      logic [7:0] ins;

      // pl, k, prog{3,2,1,0}, writes, done cycle
      vecs[0] = '{pl: 4'd0, k: 8'd1, prog: {8'hC0, 8'hC0, 8'hC0, 8'h21},
                  exp_writes: 8'd1, exp_done: 8'd4};
      vecs[1] = '{pl: 4'd2, k: 8'd5, prog: {8'hC0, 8'h1B, 8'h07, 8'h21},
                  exp_writes: 8'd15, exp_done: 8'd46};
      vecs[2] = '{pl: 4'd2, k: 8'd0, prog: {8'hC0, 8'h1B, 8'h07, 8'h21},
                  exp_writes: 8'd0, exp_done: 8'd1};
      vecs[3] = '{pl: 4'd2, k: 8'd1, prog: {8'hC0, 8'h1B, 8'hF6, 8'h21},
                  exp_writes: 8'd2, exp_done: 8'd10};
      vecs[4] = '{pl: 4'd3, k: 8'd2, prog: {8'hC0, 8'h0B, 8'hA5, 8'h74},
                  exp_writes: 8'd6, exp_done: 8'd25};

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.prog_last = '0;
      bus.iter_cnt  = '0;
      for (int i = 0; i < 16; i++) im[i] = 8'hC0;
      rf_init();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_im_addr", bus.im_addr, 0);
      chk("rst_rs1", bus.rs1, 0);
      chk("rst_rs2", bus.rs2, 0);
      chk("rst_rd", bus.rd, 0);
      chk("rst_alu_op", bus.alu_op, 0);
      chk("rst_reg_we", bus.reg_we, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_iter_left", bus.iter_left, 0);
      rst = 1'b0;
      tick();

      for (int v = 0; v < 5; v++) begin
         n  = int'(vecs[v].pl) + 1;
         k  = int'(vecs[v].k);
         dc = int'(vecs[v].exp_done);
         for (int i = 0; i < 16; i++) begin
            if (i < 4) im[i] = vecs[v].prog[i];
            else       im[i] = 8'hC0;
         end
         rf_init();
         bus.prog_last = vecs[v].pl;
         bus.iter_cnt  = vecs[v].k;
         bus.start     = 1'b1;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         for (int c = 1; c <= dc + 1; c++) begin
            chk("busy", bus.busy, c < dc);
            chk("done", bus.done, c == dc);
            if (c >= 3 && c % 3 == 0 && (c - 3) / 3 < n * k) begin
               idx = ((c - 3) / 3) % n;
               ins = im[idx];
               chk("reg_we", bus.reg_we, ins[7:6] != 2'b11);
               chk("rd", bus.rd, ins[5:4]);
               chk("rs1", bus.rs1, ins[3:2]);
               chk("rs2", bus.rs2, ins[1:0]);
               chk("alu_op", bus.alu_op, ins[7:6]);
            end else begin
               chk("reg_we_off", bus.reg_we, 0);
            end
            if (c < dc && c % 3 == 1) chk("im_addr", bus.im_addr, ((c - 1) / 3) % n);
            if (c < dc) chk("iter_left", bus.iter_left, k - (c - 1) / (3 * n));
            tick();
         end
         chk("writes", wr_cnt, vecs[v].exp_writes);
         if (v == 1) begin
            fa = 0;
            fb = 1;
            for (int p = 0; p < k; p++) begin
               fc = fa + fb;
               fa = fb;
               fb = fc;
            end
            chk("fib_r1", rf[1], fb);
         end
      end

      // Abort in the second WRITE of the Fibonacci run, then a clean restart
      load_fib();
      rf_init();
      bus.prog_last = 4'd2;
      bus.iter_cnt  = 8'd5;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) tick();
      bus.abort = 1'b1;
      #1;
      chk("abort_reg_we", bus.reg_we, 0);
      chk("abort_busy_write", bus.busy, 1);
      tick();
      bus.abort = 1'b0;
      chk("abort_idle", bus.busy, 0);
      chk("abort_no_done7", bus.done, 0);
      chk("abort_writes", wr_cnt, 1);
      tick();
      chk("abort_no_done8", bus.done, 0);
      bus.prog_last = 4'd0;
      bus.iter_cnt  = 8'd1;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("restart_busy", bus.busy, 1);
      tick();
      tick();
      chk("restart_we", bus.reg_we, 1);
      chk("restart_rd", bus.rd, 2);
      tick();
      chk("restart_done", bus.done, 1);
      tick();

      // start and abort together in IDLE: nothing starts
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_idle", bus.busy, 0);
      tick();
      chk("start_abort_no_done", bus.done, 0);

      // start held high while busy and in DONE is ignored
      bus.prog_last = 4'd0;
      bus.iter_cnt  = 8'd1;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.prog_last = 4'd2;
      bus.iter_cnt  = 8'd3;
      bus.start     = 1'b1;
      tick();
      chk("busy_start_we", bus.reg_we, 1);
      chk("busy_start_iter", bus.iter_left, 1);
      tick();
      chk("busy_start_done", bus.done, 1);
      tick();
      bus.start = 1'b0;
      chk("done_start_ignored", bus.busy, 0);
      tick();
      chk("done_start_idle", bus.busy, 0);

      // Asynchronous reset mid-run
      load_fib();
      rf_init();
      bus.prog_last = 4'd2;
      bus.iter_cnt  = 8'd5;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_im_addr", bus.im_addr, 0);
      chk("arst_rs1", bus.rs1, 0);
      chk("arst_rs2", bus.rs2, 0);
      chk("arst_rd", bus.rd, 0);
      chk("arst_alu_op", bus.alu_op, 0);
      chk("arst_reg_we", bus.reg_we, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_done", bus.done, 0);
      chk("arst_iter_left", bus.iter_left, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("post_rst_busy", bus.busy, 0);
         chk("post_rst_we", bus.reg_we, 0);
         chk("post_rst_done", bus.done, 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
